// File: rtl/comparator_seq.sv
// Multi-cycle magnitude comparator: compares two WIDTH-bit operands MSB-first, CHUNK bits per clock.
// Optional two's-complement mode when COMPARATOR_SEQ_SIGNED_EN is defined (adds the is_signed input).
module comparator_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] w0,
    input  logic [WIDTH-1:0] w1,
`ifdef COMPARATOR_SEQ_SIGNED_EN
    input  logic             is_signed,
`endif
    output logic             busy,
    output logic             done,
    output logic             less,
    output logic             equal,
    output logic             greater
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] TOP_IDX = IDXW'(NCHUNK - 1);

    typedef enum logic {IDLE, CMP} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [IDXW-1:0]  idx_q;
    logic             busy_q, done_q, less_q, equal_q, greater_q;
`ifdef COMPARATOR_SEQ_SIGNED_EN
    logic             sgn_q;
`endif

    logic [CHUNK-1:0] a_chunk_d, b_chunk_d;
    int unsigned      lsb_d;

    // Select the current chunk; in signed mode flip the sign bit of the top chunk.
    always_comb begin
        lsb_d     = 32'(idx_q) * CHUNK;
        a_chunk_d = a_q[lsb_d +: CHUNK];
        b_chunk_d = b_q[lsb_d +: CHUNK];
`ifdef COMPARATOR_SEQ_SIGNED_EN
        if (sgn_q && (idx_q == TOP_IDX)) begin
            a_chunk_d[CHUNK-1] = ~a_chunk_d[CHUNK-1];
            b_chunk_d[CHUNK-1] = ~b_chunk_d[CHUNK-1];
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            less_q    <= 1'b0;
            equal_q   <= 1'b0;
            greater_q <= 1'b0;
`ifdef COMPARATOR_SEQ_SIGNED_EN
            sgn_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= w0;
                        b_q     <= w1;
                        idx_q   <= TOP_IDX;
                        busy_q  <= 1'b1;
                        state_q <= CMP;
`ifdef COMPARATOR_SEQ_SIGNED_EN
                        sgn_q   <= is_signed;
`endif
                    end
                end
                CMP: begin
                    if (a_chunk_d != b_chunk_d) begin
                        greater_q <= (a_chunk_d > b_chunk_d);
                        less_q    <= (a_chunk_d < b_chunk_d);
                        equal_q   <= 1'b0;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end else if (idx_q == '0) begin
                        greater_q <= 1'b0;
                        less_q    <= 1'b0;
                        equal_q   <= 1'b1;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        idx_q <= idx_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign less    = less_q;
    assign equal   = equal_q;
    assign greater = greater_q;

endmodule

// File: tb/tb_comparator_seq.sv
// Directed bench for comparator_seq (WIDTH=32, CHUNK=4): vector table plus handshake/reset sequences.
module tb_comparator_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] w0, w1;
`ifdef COMPARATOR_SEQ_SIGNED_EN
    logic        is_signed;
`endif
    logic        busy, done, less, equal, greater;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    comparator_seq #(.WIDTH(32), .CHUNK(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .w0      (w0),
        .w1      (w1),
`ifdef COMPARATOR_SEQ_SIGNED_EN
        .is_signed(is_signed),
`endif
        .busy    (busy),
        .done    (done),
        .less    (less),
        .equal   (equal),
        .greater (greater)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        l, e, g;
        int          k;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Launch one compare; k = edges after the accepting edge until done is seen.
    task automatic do_cmp(input logic [31:0] a, input logic [31:0] b, output int k);
        @(negedge clk);
        w0 = a; w1 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (done !== 1'b1 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
    endtask

    task automatic chk_flags(input string name, input logic l, input logic e, input logic g);
        chk({name, ".less"},    32'(less),    32'(l));
        chk({name, ".equal"},   32'(equal),   32'(e));
        chk({name, ".greater"}, 32'(greater), 32'(g));
    endtask

    vec_t vt[9];
    int   k;
    int   snap;

    initial begin
        vt[0] = '{32'h12345678, 32'h12345678, 1'b0, 1'b1, 1'b0, 8};
        vt[1] = '{32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 1};
        vt[2] = '{32'h12345670, 32'h12345678, 1'b1, 1'b0, 1'b0, 8};
        vt[3] = '{32'h12345778, 32'h12345678, 1'b0, 1'b0, 1'b1, 6};
        vt[4] = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 1'b0, 8};
        vt[5] = '{32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1'b1, 1};
        vt[6] = '{32'h00000000, 32'h00000001, 1'b1, 1'b0, 1'b0, 8};
        vt[7] = '{32'h0F000000, 32'h0E000000, 1'b0, 1'b0, 1'b1, 2};
        vt[8] = '{32'hA5A5A5A4, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0, 8};

        rst = 1'b1; start = 1'b0; w0 = '0; w1 = '0;
`ifdef COMPARATOR_SEQ_SIGNED_EN
        is_signed = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.done", 32'(done), 32'd0);
        chk_flags("reset", 1'b0, 1'b0, 1'b0);
        @(negedge clk); rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_flags("pre_first_done", 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 9; i++) begin
            do_cmp(vt[i].a, vt[i].b, k);
            chk($sformatf("vec%0d.latency", i), 32'(k), 32'(vt[i].k));
            chk($sformatf("vec%0d.busy_at_done", i), 32'(busy), 32'd0);
            chk_flags($sformatf("vec%0d", i), vt[i].l, vt[i].e, vt[i].g);
            @(posedge clk); #1;
            chk($sformatf("vec%0d.done_pulse", i), 32'(done), 32'd0);
        end

        // Flags hold during a new compare; operand changes mid-compare are ignored; re-start ignored.
        do_cmp(32'h80000000, 32'h7FFFFFFF, k);
        @(negedge clk);
        w0 = 32'h12345678; w1 = 32'h12345678; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("hold.busy", 32'(busy), 32'd1);
        snap = done_cnt;
        @(posedge clk); #1;
        start = 1'b1; w0 = 32'h00000000; w1 = 32'hFFFFFFFF;
        @(posedge clk); #1;
        start = 1'b0;
        chk_flags("hold.mid", 1'b0, 1'b0, 1'b1);
        k = 2;
        while (done !== 1'b1 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        chk("hold.latency", 32'(k), 32'd8);
        chk_flags("hold.result", 1'b0, 1'b1, 1'b0);
        repeat (12) @(posedge clk);
        #1;
        chk("restart_ignored.done_count", 32'(done_cnt - snap), 32'd1);

        // start held high through the done cycle: back-to-back compare.
        @(negedge clk);
        w0 = 32'h80000000; w1 = 32'h7FFFFFFF; start = 1'b1;
        @(posedge clk); #1;
        k = 0;
        while (done !== 1'b1 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        chk("b2b.first_latency", 32'(k), 32'd1);
        chk_flags("b2b.first", 1'b0, 1'b0, 1'b1);
        w0 = 32'h00000000; w1 = 32'h00000001;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b.busy_again", 32'(busy), 32'd1);
        k = 0;
        while (done !== 1'b1 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        chk("b2b.second_latency", 32'(k), 32'd8);
        chk_flags("b2b.second", 1'b1, 1'b0, 1'b0);

        // Asynchronous reset mid-compare.
        @(negedge clk);
        w0 = 32'hDEADBEEF; w1 = 32'hDEADBEEF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst.busy", 32'(busy), 32'd0);
        chk("arst.done", 32'(done), 32'd0);
        chk_flags("arst", 1'b0, 1'b0, 1'b0);
        snap = done_cnt;
        @(negedge clk); rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("arst.no_done", 32'(done_cnt - snap), 32'd0);
        chk("arst.idle", 32'(busy), 32'd0);
        do_cmp(32'h12345778, 32'h12345678, k);
        chk("arst.fresh_latency", 32'(k), 32'd6);
        chk_flags("arst.fresh", 1'b0, 1'b0, 1'b1);

`ifdef COMPARATOR_SEQ_SIGNED_EN
        is_signed = 1'b1;
        do_cmp(32'h80000000, 32'h7FFFFFFF, k);
        chk("sgn1.latency", 32'(k), 32'd1);
        chk_flags("sgn1", 1'b1, 1'b0, 1'b0);
        is_signed = 1'b0;
        do_cmp(32'h80000000, 32'h7FFFFFFF, k);
        chk("sgn0.latency", 32'(k), 32'd1);
        chk_flags("sgn0", 1'b0, 1'b0, 1'b1);
        is_signed = 1'b1;
        do_cmp(32'hFFFFFFFF, 32'hFFFFFFFE, k);
        chk("sgn2.latency", 32'(k), 32'd8);
        chk_flags("sgn2", 1'b0, 1'b0, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
